// File: rtl/tcdm_interconnect_pkg.sv
// Shared definitions for the TCDM interconnect leaves: topology selector
// and the index-width helper used to size requester indices.
package tcdm_interconnect_pkg;

  typedef enum logic [1:0] {
    LIC,
    BFLY2,
    BFLY4,
    CLOS
  } topo_t;

  // Width needed to index n requesters; a single requester still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcdm_resp_pipe.sv
// {vld, idx} delay line of depth Depth. It remembers which requester owns
// each in-flight bank access so the response can be routed back to it.
module tcdm_resp_pipe
  import tcdm_interconnect_pkg::*;
#(
  parameter int Depth    = 1,
  parameter int IdxWidth = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pushVld,
  input  logic [IdxWidth-1:0] pushIdx,
  output logic                popVld,
  output logic [IdxWidth-1:0] popIdx
);

  logic [Depth-1:0]    vldQ;
  logic [IdxWidth-1:0] idxQ [Depth];

  // Valid bits shift every cycle; reset drops everything in flight.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every stage samples its predecessor's
    // pre-edge value; blocking here would collapse the pipe into one stage.
    if (rst_i) begin
      vldQ <= '0;
    end else begin
      vldQ[0] <= pushVld;
      for (int s = 1; s < Depth; s++) begin
        vldQ[s] <= vldQ[s-1];
      end
    end
  end

  // Index payload shifts alongside the valid bits.
  always_ff @(posedge clk_i) begin
    // NOTE: the index storage is left unreset on purpose; it is only ever
    // looked at when the matching valid bit is set, and that bit is reset.
    idxQ[0] <= pushIdx;
    for (int s = 1; s < Depth; s++) begin
      idxQ[s] <= idxQ[s-1];
    end
  end

  assign popVld = vldQ[Depth-1];
  assign popIdx = idxQ[Depth-1];

endmodule

// File: rtl/tcdm_bank_rr_arb.sv
// Per-bank round-robin arbiter and response router. Shares one
// single-ported SRAM bank among NumIn requesters and returns each response
// to its originator MemLatency cycles after the grant.
module tcdm_bank_rr_arb
  import tcdm_interconnect_pkg::*;
#(
  parameter int NumIn      = 4,
  parameter int AddrWidth  = 10,
  parameter int DataWidth  = 32,
  parameter int BeWidth    = DataWidth / 8,
  parameter int MemLatency = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumIn-1:0]               req_i,
  input  logic [NumIn*AddrWidth-1:0]     add_i,
  input  logic [NumIn-1:0]               wen_i,
  input  logic [NumIn*DataWidth-1:0]     wdata_i,
  input  logic [NumIn*BeWidth-1:0]       be_i,
  output logic [NumIn-1:0]               gnt_o,
  output logic [NumIn-1:0]               vld_o,
  output logic [NumIn*DataWidth-1:0]     rdata_o,
  output logic                           bank_req_o,
  output logic [AddrWidth-1:0]           bank_add_o,
  output logic                           bank_wen_o,
  output logic [DataWidth-1:0]           bank_wdata_o,
  output logic [BeWidth-1:0]             bank_be_o,
  input  logic                           bank_gnt_i,
  input  logic [DataWidth-1:0]           bank_rdata_i
);

  localparam int IdxWidth = idx_width(NumIn);

  if (NumIn < 1) begin : gen_bad_num_in
    $error("tcdm_bank_rr_arb: NumIn must be at least 1");
  end
  if (MemLatency < 1 || MemLatency > 4) begin : gen_bad_latency
    $error("tcdm_bank_rr_arb: MemLatency must be in 1..4");
  end
  if (BeWidth * 8 != DataWidth) begin : gen_bad_be
    $error("tcdm_bank_rr_arb: BeWidth*8 must equal DataWidth");
  end

  logic [IdxWidth-1:0] rrQ;
  logic [IdxWidth-1:0] rrNext;
  logic [IdxWidth-1:0] winIdx;
  logic [IdxWidth-1:0] respIdx;
  logic                bankReq;
  logic                handshake;
  logic                respVld;

  // Cyclic search from rrQ: lowest requester at or above rrQ, else lowest overall.
  always_comb begin
    // NOTE: assign a default before any conditional update so no path leaves
    // winIdx unassigned; otherwise synthesis infers a latch.
    winIdx = '0;
    for (int i = NumIn - 1; i >= 0; i--) begin
      if (req_i[i]) winIdx = IdxWidth'(i);
    end
    for (int i = NumIn - 1; i >= 0; i--) begin
      if (req_i[i] && (IdxWidth'(i) >= rrQ)) winIdx = IdxWidth'(i);
    end
  end

  // Bank-side request is silenced while reset is held.
  assign bankReq    = (|req_i) & ~rst_i;
  assign handshake  = bankReq & bank_gnt_i;
  assign bank_req_o = bankReq;

  // Pointer moves just past the winner, wrapping at NumIn (not at 2**IdxWidth).
  assign rrNext = (winIdx == IdxWidth'(NumIn - 1)) ? '0 : winIdx + IdxWidth'(1);

  // Forward the winner's lane to the bank and grant it when the bank accepts.
  always_comb begin
    gnt_o        = '0;
    bank_add_o   = '0;
    bank_wen_o   = 1'b0;
    bank_wdata_o = '0;
    bank_be_o    = '0;
    for (int i = 0; i < NumIn; i++) begin
      if (bankReq && (winIdx == IdxWidth'(i))) begin
        gnt_o[i]     = bank_gnt_i;
        bank_add_o   = add_i[i*AddrWidth +: AddrWidth];
        bank_wen_o   = wen_i[i];
        bank_wdata_o = wdata_i[i*DataWidth +: DataWidth];
        bank_be_o    = be_i[i*BeWidth +: BeWidth];
      end
    end
  end

  // Round-robin pointer advances only on an accepted access.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rrQ <= '0;
    end else if (handshake) begin
      rrQ <= rrNext;
    end
  end

  tcdm_resp_pipe #(
    .Depth    (MemLatency),
    .IdxWidth (IdxWidth)
  ) i_resp_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pushVld (handshake),
    .pushIdx (winIdx),
    .popVld  (respVld),
    .popIdx  (respIdx)
  );

  // Route the bank's read data to the owner of the retiring access; reads and
  // writes both report a response. A response retiring during reset is dropped.
  always_comb begin
    vld_o   = '0;
    rdata_o = '0;
    for (int i = 0; i < NumIn; i++) begin
      if (respVld && !rst_i && (respIdx == IdxWidth'(i))) begin
        vld_o[i]                          = 1'b1;
        rdata_o[i*DataWidth +: DataWidth] = bank_rdata_i;
      end
    end
  end

  // Protocol checks: grants and responses are exclusive, requests are held.
  assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o))
    else $error("gnt_o is not onehot0");
  assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(vld_o))
    else $error("vld_o is not onehot0");

  for (genvar g = 0; g < NumIn; g++) begin : gen_req_hold
    assert property (@(posedge clk_i) disable iff (rst_i)
                     (req_i[g] && !gnt_o[g]) |=> req_i[g])
      else $error("req_i[%0d] withdrawn before grant", g);
  end

endmodule

// File: tb/tb_tcdm_bank_rr_arb.sv
// Bench for tcdm_bank_rr_arb: a 4-input, latency-2 instance checked every
// cycle against a queue-based reference model, plus a 3-input, latency-1
// instance for the non-power-of-two wrap case. Directed literal checks pin
// the model to hand-derived values.
module tb_tcdm_bank_rr_arb;

  localparam int NumIn      = 4;
  localparam int AddrWidth  = 10;
  localparam int DataWidth  = 32;
  localparam int BeWidth    = 4;
  localparam int MemLatency = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance signals.
  logic [NumIn-1:0]           req, wen, gnt, vld;
  logic [NumIn*AddrWidth-1:0] add;
  logic [NumIn*DataWidth-1:0] wdata, rdata;
  logic [NumIn*BeWidth-1:0]   be;
  logic                       bankReq, bankWen, bankGnt;
  logic [AddrWidth-1:0]       bankAdd;
  logic [DataWidth-1:0]       bankWdata, bankRdata;
  logic [BeWidth-1:0]         bankBe;

  // Three-requester instance signals.
  logic [2:0]           req3, wen3, gnt3, vld3;
  logic [3*AddrWidth-1:0] add3;
  logic [3*DataWidth-1:0] wdata3, rdata3;
  logic [3*BeWidth-1:0]   be3;
  logic                 bankReq3, bankWen3, bankGnt3;
  logic [AddrWidth-1:0] bankAdd3;
  logic [DataWidth-1:0] bankWdata3, bankRdata3;
  logic [BeWidth-1:0]   bankBe3;

  int checks = 0;
  int passes = 0;

  tcdm_bank_rr_arb #(
    .NumIn(NumIn), .AddrWidth(AddrWidth), .DataWidth(DataWidth),
    .BeWidth(BeWidth), .MemLatency(MemLatency)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen),
    .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .vld_o(vld), .rdata_o(rdata),
    .bank_req_o(bankReq), .bank_add_o(bankAdd), .bank_wen_o(bankWen),
    .bank_wdata_o(bankWdata), .bank_be_o(bankBe), .bank_gnt_i(bankGnt),
    .bank_rdata_i(bankRdata)
  );

  tcdm_bank_rr_arb #(
    .NumIn(3), .AddrWidth(AddrWidth), .DataWidth(DataWidth),
    .BeWidth(BeWidth), .MemLatency(1)
  ) dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req3), .add_i(add3), .wen_i(wen3),
    .wdata_i(wdata3), .be_i(be3), .gnt_o(gnt3), .vld_o(vld3), .rdata_o(rdata3),
    .bank_req_o(bankReq3), .bank_add_o(bankAdd3), .bank_wen_o(bankWen3),
    .bank_wdata_o(bankWdata3), .bank_be_o(bankBe3), .bank_gnt_i(bankGnt3),
    .bank_rdata_i(bankRdata3)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passes++;
  endtask

  // Bank model for the main instance: byte-enabled writes, reads return
  // MemLatency cycles after acceptance, idle slots carry a junk pattern.
  logic [DataWidth-1:0] mem [1024];
  logic [DataWidth-1:0] rdPipe [MemLatency];
  always @(posedge clk) begin
    if (bankReq && bankGnt) begin
      if (bankWen) begin
        for (int b = 0; b < BeWidth; b++)
          if (bankBe[b]) mem[bankAdd][8*b +: 8] <= bankWdata[8*b +: 8];
        rdPipe[0] <= '0;
      end else begin
        rdPipe[0] <= mem[bankAdd];
      end
    end else begin
      rdPipe[0] <= 32'hBAD0_0000;
    end
    for (int s = 1; s < MemLatency; s++) rdPipe[s] <= rdPipe[s-1];
  end
  assign bankRdata  = rdPipe[MemLatency-1];
  assign bankRdata3 = 32'h3333_CAFE;
  assign bankGnt3   = 1'b1;

  // Reference model: cyclic pointer plus a queue of {due cycle, requester}.
  typedef struct {
    int due;
    int idx;
  } resp_t;

  resp_t pend[$];
  int    mdlPtr = 0;
  int    cyc = 0;

  always @(negedge clk) begin : compare
    int                   win;
    int                   c;
    logic                 hs;
    logic [NumIn-1:0]     eGnt, eVld;
    logic [127:0]         eRdata;
    logic                 eReq, eWen;
    logic [AddrWidth-1:0] eAdd;
    logic [DataWidth-1:0] eWdata;
    logic [BeWidth-1:0]   eBe;

    eGnt = '0; eVld = '0; eRdata = '0; eReq = 1'b0; eWen = 1'b0;
    eAdd = '0; eWdata = '0; eBe = '0;
    if (rst) begin
      pend.delete();
      mdlPtr = 0;
    end else begin
      win = -1;
      for (int k = 0; k < NumIn; k++) begin
        c = (mdlPtr + k) % NumIn;
        if (win < 0 && req[c]) win = c;
      end
      if (win >= 0) begin
        eReq   = 1'b1;
        eAdd   = AddrWidth'(add >> (win * AddrWidth));
        eWen   = wen[win];
        eWdata = DataWidth'(wdata >> (win * DataWidth));
        eBe    = BeWidth'(be >> (win * BeWidth));
      end
      hs = (win >= 0) && bankGnt;
      if (hs) eGnt = NumIn'(1) << win;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        eVld   = NumIn'(1) << pend[0].idx;
        eRdata = 128'(bankRdata) << (pend[0].idx * DataWidth);
        void'(pend.pop_front());
      end
      if (hs) begin
        pend.push_back('{due: cyc + MemLatency, idx: win});
        mdlPtr = (win + 1) % NumIn;
      end
    end
    check("cyc_gnt", gnt, eGnt);
    check("cyc_vld", vld, eVld);
    check("cyc_rdata", rdata, eRdata);
    check("cyc_bank_req", bankReq, eReq);
    check("cyc_bank_add", bankAdd, eAdd);
    check("cyc_bank_wen", bankWen, eWen);
    check("cyc_bank_wdata", bankWdata, eWdata);
    check("cyc_bank_be", bankBe, eBe);
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of requests, check the same-cycle grant, advance.
  task automatic step(input string name, input logic [NumIn-1:0] r, input logic g,
                      input logic [NumIn-1:0] gExp);
    req = r;
    bankGnt = g;
    #1;
    check(name, gnt, gExp);
    tick();
  endtask

  task automatic set_lane(input int l, input logic [AddrWidth-1:0] a, input logic w,
                          input logic [DataWidth-1:0] d, input logic [BeWidth-1:0] b);
    add[l*AddrWidth +: AddrWidth] = a;
    wen[l]                        = w;
    wdata[l*DataWidth +: DataWidth] = d;
    be[l*BeWidth +: BeWidth]      = b;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    logic [127:0] tmp;
    int           lane;

    rst = 1'b1; req = '0; bankGnt = 1'b1;
    for (int i = 0; i < NumIn; i++)
      set_lane(i, AddrWidth'(10'h100 + i), 1'b0, 32'hC0DE_0000 + i, 4'hF);
    req3 = '0; wen3 = '0; add3 = '0; wdata3 = '0; be3 = '0;
    tick();
    tick();

    // Reset state: outputs quiet even with every requester asserting.
    req = 4'b1111;
    #1;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_bank_req", bankReq, 1'b0);
    check("rst_vld", vld, 4'b0000);
    check("rst_rdata", rdata, 128'h0);
    tick();
    rst = 1'b0;

    // All four requesting: rotating grants, responses two cycles later.
    for (int k = 0; k < 8; k++) begin
      check("t1_vld", vld, (k >= 2) ? (4'b0001 << ((k - 2) % 4)) : 4'b0000);
      if (k >= 2) begin
        lane = (k - 2) % 4;
        tmp = rdata >> (32 * lane);
        check("t1_rdata_lane", tmp[31:0], bankRdata);
      end
      step("t1_gnt", 4'b1111, 1'b1, 4'b0001 << (k % 4));
    end
    check("t1_model_ptr", mdlPtr, 0);

    // Drain: each requester withdraws only after its own grant.
    step("drain_a0", 4'b1111, 1'b1, 4'b0001);
    step("drain_a1", 4'b1110, 1'b1, 4'b0010);
    step("drain_a2", 4'b1100, 1'b1, 4'b0100);
    step("drain_a3", 4'b1000, 1'b1, 4'b1000);

    // Move the pointer to 2, then exercise wrap-around from 2 to 0.
    step("t2_prep0", 4'b0011, 1'b1, 4'b0001);
    step("t2_prep1", 4'b0010, 1'b1, 4'b0010);
    check("t2_model_ptr_start", mdlPtr, 2);
    step("t2_wrap", 4'b0011, 1'b1, 4'b0001);
    step("t2_next", 4'b0010, 1'b1, 4'b0010);
    check("t2_model_ptr_end", mdlPtr, 2);

    // Bank stall: no grant, pointer held, address stays on lane 2.
    for (int k = 0; k < 3; k++) begin
      req = 4'b0100;
      bankGnt = 1'b0;
      #1;
      check("t4_stall_add", bankAdd, 10'h102);
      check("t4_stall_req", bankReq, 1'b1);
      step("t4_stall_gnt", 4'b0100, 1'b0, 4'b0000);
    end
    step("t4_release", 4'b0100, 1'b1, 4'b0100);
    check("t4_vld_early", vld, 4'b0000);
    step("t4_idle", 4'b0000, 1'b1, 4'b0000);
    check("t4_vld", vld, 4'b0100);

    // Write by lane 1 then read of the same word by lane 3.
    set_lane(1, 10'h155, 1'b1, 32'hDEAD_BEEF, 4'hF);
    set_lane(3, 10'h155, 1'b0, 32'h0, 4'hF);
    req = 4'b0010;
    #1;
    check("t5_wdata", bankWdata, 32'hDEAD_BEEF);
    check("t5_wen", bankWen, 1'b1);
    check("t5_wadd", bankAdd, 10'h155);
    step("t5_wgnt", 4'b0010, 1'b1, 4'b0010);
    req = 4'b1000;
    #1;
    check("t5_ren", bankWen, 1'b0);
    step("t5_rgnt", 4'b1000, 1'b1, 4'b1000);
    check("t5_wvld", vld, 4'b0010);
    step("t5_idle0", 4'b0000, 1'b1, 4'b0000);
    check("t5_rvld", vld, 4'b1000);
    tmp = rdata >> 96;
    check("t5_rdata", tmp[31:0], 32'hDEAD_BEEF);
    step("t5_idle1", 4'b0000, 1'b1, 4'b0000);
    set_lane(1, 10'h101, 1'b0, 32'hC0DE_0001, 4'hF);

    // Reset with two grants in flight: both dropped, pointer back to 0.
    step("t6_g0", 4'b1111, 1'b1, 4'b0001);
    step("t6_g1", 4'b1111, 1'b1, 4'b0010);
    rst = 1'b1;
    #1;
    check("t6_rst_gnt", gnt, 4'b0000);
    check("t6_rst_vld", vld, 4'b0000);
    tick();
    rst = 1'b0;
    check("t6_drop0", vld, 4'b0000);
    step("t6_first", 4'b1111, 1'b1, 4'b0001);
    check("t6_drop1", vld, 4'b0000);
    step("t6_d1", 4'b1110, 1'b1, 4'b0010);
    check("t6_vld_after", vld, 4'b0001);
    step("t6_d2", 4'b1100, 1'b1, 4'b0100);
    step("t6_d3", 4'b1000, 1'b1, 4'b1000);
    step("t6_idle0", 4'b0000, 1'b1, 4'b0000);

    // Three requesters: granting index 2 wraps the pointer to 0.
    req3 = 3'b100;
    #1;
    check("t3_gnt_wrap", gnt3, 3'b100);
    tick();
    req3 = 3'b111;
    #1;
    check("t3_vld2", vld3, 3'b100);
    tmp = rdata3 >> 64;
    check("t3_rdata2", tmp[31:0], 32'h3333_CAFE);
    check("t3_gnt_after_wrap", gnt3, 3'b001);
    tick();
    req3 = 3'b110;
    #1;
    check("t3_vld0", vld3, 3'b001);
    check("t3_gnt1", gnt3, 3'b010);
    tick();
    req3 = 3'b100;
    #1;
    check("t3_gnt2", gnt3, 3'b100);
    tick();
    req3 = 3'b000;
    #1;
    check("t3_vld_last", vld3, 3'b100);
    check("t3_rdata_others", rdata3[63:0], 64'h0);
    tick();

    step("final_idle0", 4'b0000, 1'b1, 4'b0000);
    step("final_idle1", 4'b0000, 1'b1, 4'b0000);
    step("final_idle2", 4'b0000, 1'b1, 4'b0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
